// File: rtl/systolic_ctrl_if.sv
// Operand-load / run-control / array-drive bundle between the systolic sequencer and its users.
interface systolic_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
);
  logic                      wr_en;
  logic                      wr_sel;
  logic [$clog2(N*N)-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      arr_rst_n;
  logic [N*DATA_WIDTH-1:0]   left_out;
  logic [N*DATA_WIDTH-1:0]   top_out;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, arr_rst_n, left_out, top_out
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, arr_rst_n, left_out, top_out
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary MAC array: buffers A and B, clears the PEs,
// then feeds skewed wavefronts so A[i][k] and B[k][j] meet at PE(i,j) on FEED cycle k+i+j.
module systolic_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_ctrl_if.slave bus
);
  localparam int AW     = $clog2(N*N);
  localparam int T_LAST = 3*N - 3;
  localparam int TW     = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                  state, state_n;
  logic [TW-1:0]           t, t_n;
  logic [DATA_WIDTH-1:0]   a_buf [N*N];
  logic [DATA_WIDTH-1:0]   b_buf [N*N];
  logic                    wr_ok;
  logic [N*DATA_WIDTH-1:0] left_n, top_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE: begin
        t_n = '0;
        if (bus.start) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == TW'(T_LAST)) begin
          state_n = DONE;
          t_n     = '0;
        end else begin
          t_n = t + TW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        t_n     = '0;
      end
    endcase
  end

  // Buffers only change outside CLEAR/FEED, so the feed always sees a stable snapshot.
  always_comb wr_ok = bus.wr_en && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N*N; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (wr_ok) begin
      if (bus.wr_sel) b_buf[bus.wr_addr] <= bus.wr_data;
      else            a_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Lanes are computed from the next state/counter so the registered outputs line up with FEED.
  always_comb begin
    left_n = '0;
    top_n  = '0;
    if (state_n == FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (int'(t_n) >= int'(i) && int'(t_n) - int'(i) < N) begin
          left_n[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[AW'(int'(i)*N + int'(t_n) - int'(i))];
          top_n[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf[AW'((int'(t_n) - int'(i))*N + int'(i))];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.arr_rst_n <= 1'b0;
      bus.left_out  <= '0;
      bus.top_out   <= '0;
    end else begin
      bus.busy      <= (state_n == CLEAR) || (state_n == FEED);
      bus.done      <= (state_n == DONE);
      bus.arr_rst_n <= (state_n != CLEAR);
      bus.left_out  <= left_n;
      bus.top_out   <= top_n;
    end
  end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the 4x4 output-stationary systolic array of MAC PEs. It holds operand matrices A (NxN) and B (NxN) in local register buffers, loaded through a simple write port. On `start` it clears the PE accumulators, then drives skewed operand wavefronts onto the array's left and top edges. After the last product has been accumulated it pulses `done`, at which point every PE `result` holds C = A·B.

## Interface
- `DATA_WIDTH`, 8: operand width; PE results are 2*DATA_WIDTH, unsigned, wrapping.
- `N`, 4: array dimension and matrix size (K = N).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: operand buffer write strobe.
- `wr_sel` in 1: 0 = A buffer, 1 = B buffer.
- `wr_addr` in $clog2(N*N): A address = i*N+k (row i, col k); B address = k*N+j (row k, col j).
- `wr_data` in DATA_WIDTH: operand value.
- `start` in 1: run request; level sampled in IDLE only.
- `busy` out 1: high in CLEAR and FEED.
- `done` out 1: one-cycle pulse; PE results valid this cycle.
- `arr_rst_n` out 1: registered active-low clear to all PE `rst_n` pins.
- `left_out` out N*DATA_WIDTH: lane i (bits i*DATA_WIDTH +: DATA_WIDTH) to `left_in` of PE(i,0).
- `top_out` out N*DATA_WIDTH: lane j to `top_in` of PE(0,j).

## Operation
- FSM states: IDLE, CLEAR, FEED, DONE.
  - IDLE -> CLEAR on `start`.
  - CLEAR -> FEED after 1 cycle.
  - FEED -> DONE when t = 3N-3.
  - DONE -> IDLE after 1 cycle.
- CLEAR: `arr_rst_n` = 0 for exactly one cycle; operand lanes = 0.
- FEED: cycle counter t runs 0..3N-3.
  - `left_out` lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - `top_out` lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Zeros outside the window contribute nothing to the accumulators.
- Alignment: A[i][k] and B[k][j] meet at PE(i,j) on FEED cycle k+i+j. The last meeting is at PE(N-1,N-1) on t = 3N-3.
- Writes are accepted only when `busy` = 0, including in the DONE cycle. Writes while busy are dropped, so buffers are stable during FEED.
- `start` while busy or in DONE is ignored (no queuing).
- `wr_en` and `start` in the same IDLE cycle: the write is committed and the run starts with the new data.
- Buffers are not cleared by a run and are reusable for repeated runs.
- Reset (any time, including mid-FEED) returns the FSM to IDLE:
  - buffers cleared to 0, t = 0, `busy` = 0, `done` = 0;
  - `arr_rst_n` = 0 while `rst_n` is low; it releases to 1 on the first clock edge after `rst_n` deasserts;
  - `left_out` = `top_out` = 0.
- IDLE and DONE drive operand lanes to 0 and hold `arr_rst_n` = 1, so results stay frozen after done.
- All outputs are registered.

## Timing
- `start` sampled high at edge 0:
  - CLEAR occupies cycle 1;
  - FEED occupies cycles 2 .. 3N-1 (10 cycles for N=4);
  - `done` is high in cycle 3N (cycle 12 for N=4).
- The PE latches its final accumulation at the edge ending FEED, so `result` is valid while `done` = 1 and remains so until the next CLEAR.
- Minimum start-to-start interval: 3N+1 cycles (13).
- `busy` rises the cycle after `start` is sampled and falls together with the rise of `done`.

## Test plan
- A = identity, B = 1..16 row-major, start -> `done` at cycle 12; C(i,j) = B(i,j), e.g. C(3,3) = 16.
- A all 2, B all 3 -> every C = 24. Repeat start without reloading -> C = 24 again, not 48, proving CLEAR works.
- A = B all 255 -> every C = 260100 mod 65536 = 63492 (unsigned wrap).
- Skew check, monitoring lanes during FEED with A[i][k] = 16*i+k:
  - FEED t=0: `left_out` lane0 = 0x00, all other lanes = 0;
  - t=3: lane3 = 0x30, lane0 = 0x03;
  - t=7: all left lanes = 0.
- `start` pulsed at FEED t=4, plus `wr_en` to A during FEED -> no restart; `done` still at cycle 12; buffer unchanged (verify with a second run).
- `rst_n` asserted at FEED t=5, then released:
  - immediately `busy` = 0, lanes = 0, `arr_rst_n` = 0;
  - `arr_rst_n` returns to 1 at the first edge after release;
  - no `done` pulse;
  - a fresh load + start yields the correct product.
